// File: rtl/priority_encoder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared definitions for the sequential priority encoder
//                family: scan FSM state encoding and the clog2 helper used
//                to size index fields.
//  Contents    : state_t (ST_IDLE, ST_SCAN), clog2()
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // Two-state scan controller.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Ceiling log2 for widths >= 2. Evaluated at elaboration time to size
  // index buses.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/priority_encoder_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_seq_if
//  Description : Handshake bundle between a request-vector producer and the
//                sequential priority encoder, plus the index consumer side.
//  Signals     : in_valid/in_ready/in_data   - vector input handshake
//                out_valid/out_ready/out_idx - index output handshake
//                out_last                    - final index of the vector
//                zero                        - all-zero vector accepted
//                busy                        - scan in progress
//  Modports    : slave  - the encoder itself
//                master - the environment driving and consuming it
//  Revision    : 1.0 - initial release
// ============================================================================
interface priority_encoder_seq_if
  import encoder_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero;
  logic         busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero, busy
  );

endinterface : priority_encoder_seq_if
`default_nettype wire

// File: rtl/priority_encoder_seq_comb.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_comb
//  Description : Purely combinational find-first-set over an N-bit vector.
//                MSB_FIRST=0 reports the lowest set bit, MSB_FIRST=1 the
//                highest set bit.
//  Ports       : i_vec  [N-1:0] - vector to search
//                o_idx  [W-1:0] - index of the winning bit (0 when none set)
//                o_any          - at least one bit of i_vec is set
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_comb
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic [N-1:0]        i_vec,
  output logic      [clog2(N)-1:0] o_idx,
  output logic                     o_any
);
  localparam int W = clog2(N);

  // The scan order is chosen so that the last match written wins; that
  // match is the highest-priority bit for the selected direction.
  if (MSB_FIRST) begin : g_msb_first
    always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i_vec[i]) begin
          o_idx = W'(i);
          o_any = 1'b1;
        end
      end
    end
  end else begin : g_lsb_first
    always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        if (i_vec[i]) begin
          o_idx = W'(i);
          o_any = 1'b1;
        end
      end
    end
  end

endmodule : priority_encoder_comb
`default_nettype wire

// File: rtl/priority_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_seq
//  Description : Captures an N-bit request vector and emits the index of each
//                set bit, one per output handshake, in priority order
//                (lowest-first, or highest-first when MSB_FIRST=1).
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - priority_encoder_seq_if.slave:
//                       in_valid/in_ready/in_data   vector input
//                       out_valid/out_ready/out_idx index output
//                       out_last  final index of the current vector
//                       zero      one-cycle pulse, all-zero vector accepted
//                       busy      scan in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_seq
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  priority_encoder_seq_if.slave  bus
);
  localparam int W = clog2(N);

  state_t       r_state;
  logic [N-1:0] r_mask;     // bits still to be emitted
  logic         r_zero;

  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_single;
  logic [N-1:0] w_clr;
  logic         w_scan;

  priority_encoder_comb #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_ffs (
    .i_vec (r_mask),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Exactly one pending bit: clearing the lowest set bit leaves nothing.
  assign w_single = w_any && ((r_mask & (r_mask - N'(1))) == '0);
  assign w_clr    = N'(1) << w_idx;
  assign w_scan   = (r_state == ST_SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_data != '0) begin
              r_mask  <= bus.in_data;
              r_state <= ST_SCAN;
            end else begin
              r_zero <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          // in_valid/in_data are deliberately not looked at here.
          if (bus.out_ready) begin
            r_mask <= r_mask & ~w_clr;
            if (w_single) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mask  <= '0;
        end
      endcase
    end
  end

  // Every output is a decode of registered state; no input reaches an
  // output combinationally.
  assign bus.in_ready  = ~w_scan;
  assign bus.out_valid = w_scan;
  assign bus.out_idx   = w_scan ? w_idx : '0;
  assign bus.out_last  = w_scan & w_single;
  assign bus.zero      = r_zero;
  assign bus.busy      = w_scan;

endmodule : priority_encoder_seq
`default_nettype wire
